// File: rtl/cv32e40p_formal_obi_responder.sv
// Constrained OBI responder. Free stall and data inputs supply the
// nondeterminism; bounded counters keep grant and response behaviour
// legal and fair. Master-side protocol violations are recorded in a sticky flag.
module cv32e40p_formal_obi_responder #(
  parameter int MAX_OUTSTANDING  = 2,
  parameter int GNT_MAX_DELAY    = 3,
  parameter int RVALID_MAX_DELAY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        gnt_stall_i,
  input  logic        rvalid_stall_i,
  input  logic [31:0] rdata_rand_i,
  output logic [2:0]  outstanding_o,
  output logic        proto_err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int GW = (GNT_MAX_DELAY > 0) ? $clog2(GNT_MAX_DELAY + 1) : 1;
  localparam int RW = (RVALID_MAX_DELAY > 0) ? $clog2(RVALID_MAX_DELAY + 1) : 1;

  typedef enum logic {IDLE, PENDING} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            proto_err_q, proto_err_d;
  logic [GW-1:0]   gnt_cnt_q, gnt_cnt_d;
  logic [RW-1:0]   rv_cnt_q, rv_cnt_d;
  logic            fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]      cnt_q, cnt_d;

  logic full, empty, gnt, rvalid, push, pop, capture, check_en, viol;
  logic [31:0] wmask;

  // Pointer advance that wraps at the FIFO depth, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    else return p + PW'(1);
  endfunction

  // Expand byte enables into a bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign full  = (cnt_q == 3'(MAX_OUTSTANDING));
  assign empty = (cnt_q == 3'd0);

  // Reset gates both handshakes so nothing is granted or returned while rst_i is high.
  assign gnt    = ~rst_i & req_i & ~full &
                  (~gnt_stall_i | (gnt_cnt_q == GW'(GNT_MAX_DELAY)));
  assign rvalid = ~rst_i & ~empty &
                  (~rvalid_stall_i | (rv_cnt_q == RW'(RVALID_MAX_DELAY)));
  assign push   = req_i & gnt;
  assign pop    = rvalid;

  assign gnt_o         = gnt;
  assign rvalid_o      = rvalid;
  assign rdata_o       = (rvalid && !fifo_q[rptr_q]) ? rdata_rand_i : 32'h0;
  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

  // Only enabled write bytes must stay stable; reads ignore wdata entirely.
  assign wmask = be_mask(be_i);
  assign viol  = ~req_i | (addr_i != addr_q) | (we_i != we_q) | (be_i != be_q) |
                 (we_i & ((wdata_i & wmask) != (wdata_q & wmask)));

  // Request FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request FSM next state: a stalled request waits in PENDING until granted or dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && !gnt) state_d = PENDING;
      PENDING: if (gnt || !req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request FSM outputs: when to capture the request and when to check its stability.
  always_comb begin
    capture  = 1'b0;
    check_en = 1'b0;
    case (state_q)
      IDLE:    capture  = req_i & ~gnt;
      PENDING: check_en = 1'b1;
      default: ;
    endcase
  end

  // Next-state for captured request, sticky error, fairness counters and FIFO bookkeeping.
  always_comb begin
    addr_d      = capture ? addr_i  : addr_q;
    we_d        = capture ? we_i    : we_q;
    be_d        = capture ? be_i    : be_q;
    wdata_d     = capture ? wdata_i : wdata_q;
    proto_err_d = proto_err_q | (check_en & viol);

    gnt_cnt_d = gnt_cnt_q;
    if (!req_i || gnt)                                     gnt_cnt_d = '0;
    else if (!full && gnt_cnt_q != GW'(GNT_MAX_DELAY))     gnt_cnt_d = gnt_cnt_q + GW'(1);

    rv_cnt_d = rv_cnt_q;
    if (empty || rvalid)                                   rv_cnt_d = '0;
    else if (rv_cnt_q != RW'(RVALID_MAX_DELAY))            rv_cnt_d = rv_cnt_q + RW'(1);

    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
  end

  // State update; reset drops every outstanding transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
      gnt_cnt_q   <= '0;
      rv_cnt_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= 1'b0;
    end else begin
      assert (!(push && !pop && full));
      assert (!(pop && empty));
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
      gnt_cnt_q   <= gnt_cnt_d;
      rv_cnt_q    <= rv_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      if (push) fifo_q[wptr_q] <= we_i;
    end
  end

endmodule
